led_serial_rx: RTL and testbench
================================

LED_SERIAL_RX -- requirements
Module: led_serial_rx

Interface
REQ-001 Parameter WIDTH, default 16: number of bits per frame.
REQ-002 Parameter TIMEOUT, default 1024: idle clk cycles inside a frame before the frame is aborted; legal range 4..65535.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in led_word[WIDTH-1]; 0 means it lands in led_word[0].
REQ-004 clk  input  1: single system clock; all state changes on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 serial_clk  input  1: asynchronous serial shift clock from the LED-chain driver; data is valid on its rising edge.
REQ-007 serial_data  input  1: asynchronous serial data bit, paired with serial_clk.
REQ-008 led_word  output  WIDTH: last complete received frame; holds its value between frames.
REQ-009 word_valid  output  1: one-cycle pulse when led_word is updated.
REQ-010 frame_error  output  1: one-cycle pulse when a partial frame is aborted by timeout.

Function
REQ-011 serial_clk and serial_data SHALL each pass through an identical 2-flop synchronizer so that both see equal delay.
REQ-012 A serial edge SHALL be the condition synchronized serial_clk = 1 and its previous-cycle value = 0, so only rising edges count.
REQ-013 On each serial edge, the synchronized serial_data bit SHALL be shifted into an internal WIDTH-bit shift register in the order set by MSB_FIRST.
REQ-014 Latency: the shift SHALL occur on the 3rd clk rising edge after a serial_clk rise that meets setup.
REQ-015 States: IDLE (bit count 0) and RECV (bit count 1..WIDTH-1).
REQ-016 IDLE -> RECV on a serial edge.
REQ-017 RECV -> IDLE on the serial edge that captures bit WIDTH-1.
REQ-018 RECV -> IDLE on timeout.
REQ-019 On the clk edge that captures bit WIDTH-1, led_word SHALL load the complete word, including that final bit, and word_valid SHALL be 1 for exactly the following cycle.
REQ-020 Back-to-back frames SHALL need no gap: a serial edge in the cycle after frame completion SHALL start a new frame.
REQ-021 In RECV, an idle counter SHALL count clk cycles since the last serial edge, and SHALL be cleared on every serial edge and held at 0 while in IDLE.
REQ-022 When the idle counter reaches TIMEOUT-1 in RECV: frame_error SHALL pulse for one cycle, the bit count SHALL clear, the state SHALL go to IDLE, and led_word SHALL remain unchanged.
REQ-023 If a serial edge coincides with the timeout cycle, the edge SHALL win: no error, the bit is captured, and the idle counter clears.
REQ-024 word_valid and frame_error SHALL never be asserted in the same cycle.
REQ-025 Guaranteed capture requires serial_clk high time and low time of at least 3 clk cycles each; below this, edges may be lost, and the loss SHALL be reported only via the timeout.
REQ-026 The idle counter width SHALL be the minimum that holds TIMEOUT-1.

Reset
REQ-027 While rst = 1: led_word = 0, word_valid = 0, frame_error = 0, state = IDLE, bit count = 0, idle counter = 0, shift register = 0.
REQ-028 Synchronizer and previous-value flops SHALL reset to 1, so a serial_clk held high across reset release produces no false edge.
REQ-029 rst asserted mid-frame SHALL discard the partial frame with no frame_error pulse.

Structure
REQ-030 The state encoding (IDLE/RECV) and the default WIDTH of 16 SHALL live in the shared LED defines header, which is also used by the LED driver.
REQ-031 A single sub-module, sync_2ff (1-bit, reset value parameter), SHALL be instantiated twice.
REQ-032 Edge detection, shift logic, counters and outputs SHALL live in led_serial_rx itself.

Verification
REQ-033 Scenario, MSB-first capture: drive 16'hA5C3 MSB-first with 8-cycle serial_clk high/low -> led_word = 16'hA5C3 with a single word_valid pulse, 3 cycles after the 16th rise.
REQ-034 Scenario, LSB-first capture: MSB_FIRST = 0, drive bits of 16'h0001 LSB-first -> led_word = 16'h0001.
REQ-035 Scenario, timeout: send 7 bits, then idle for 1024 cycles -> frame_error pulses once, led_word keeps its previous value, and a following full frame 16'hFFFF is received correctly.
REQ-036 Scenario, back-to-back frames: send 16'h1234 then 16'h8001 with no gap -> two word_valid pulses with the correct values, in order.
REQ-037 Scenario, reset mid-frame: assert rst after 9 bits, with serial_clk held high through reset -> all outputs 0, no false edge, and the next 16 bits form a clean frame.
REQ-038 Scenario, edge/timeout coincidence: place the 5th rise so its edge lands exactly on the timeout cycle -> no frame_error, and the frame completes normally.

Source files
------------

// File: rtl/led_serial_rx_pkg.sv
// Shared LED definitions: state encoding used by the LED chain blocks,
// the default frame width, and a counter-sizing helper.
package led_serial_rx_pkg;

   // Default number of bits in one LED frame.
   localparam int LED_WIDTH = 16;

   // Receiver state: IDLE while no bit of a frame has arrived, RECV while
   // bits 1..WIDTH-1 are still outstanding.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } rx_state_e;

   // Minimum number of bits needed to hold max_val (at least 1).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/led_serial_rx_if.sv
// Serial LED link plus received-word outputs.
//   serial_clk / serial_data : driver -> receiver, asynchronous to clk
//   led_word / word_valid    : last complete frame and its update pulse
//   frame_error              : pulse when a partial frame is abandoned
//   state                    : receiver FSM state, for observation
// Handshake: there is no back-pressure. word_valid is a one-cycle strobe
// qualifying led_word; the consumer must take the word in that cycle or
// read the held led_word later. frame_error is an independent strobe and is
// never high together with word_valid.
interface led_serial_rx_if
   import led_serial_rx_pkg::*;
#(
   parameter int WIDTH = LED_WIDTH
);
   logic             serial_clk;
   logic             serial_data;
   logic [WIDTH-1:0] led_word;
   logic             word_valid;
   logic             frame_error;
   rx_state_e        state;

   modport master (
      output serial_clk, serial_data,
      input  led_word, word_valid, frame_error, state
   );

   modport slave (
      input  serial_clk, serial_data,
      output led_word, word_valid, frame_error, state
   );
endinterface

// File: rtl/led_serial_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit.
//   clk, rst : system clock, synchronous active-high reset
//   i_d      : asynchronous input
//   o_q      : synchronized output (2 clk cycles of delay)
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/led_serial_rx.sv
// led_serial_rx: receives WIDTH-bit frames from an LED-chain serial link.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of led_serial_rx_if (serial in, word/pulses out)
// Parameters: WIDTH bits per frame, TIMEOUT idle clk cycles before a partial
// frame is aborted, MSB_FIRST selects where the first received bit lands.
module led_serial_rx
   import led_serial_rx_pkg::*;
#(
   parameter int WIDTH     = LED_WIDTH,
   parameter int TIMEOUT   = 1024,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   led_serial_rx_if.slave bus
);
   localparam int              BCW      = cnt_width(WIDTH - 1);
   localparam int              ICW      = cnt_width(TIMEOUT - 1);
   localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);
   localparam logic [ICW-1:0]  IDLE_MAX = ICW'(TIMEOUT - 1);

   logic             w_sclk_sync;
   logic             w_sdata_sync;
   logic             r_sclk_prev;
   logic             w_edge;
   logic             w_timeout;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_word;
   logic [BCW-1:0]   r_bit_cnt;
   logic [ICW-1:0]   r_idle_cnt;
   logic             r_word_valid;
   logic             r_frame_error;
   rx_state_e        r_state;
   rx_state_e        w_state_nxt;

   // Clock and data share the same synchronizer so they stay aligned.
   // Both reset high so a serial_clk held high over reset is not an edge.
   sync_2ff #(.RST_VAL(1'b1)) u_sync_clk (
      .clk (clk), .rst (rst), .i_d (bus.serial_clk), .o_q (w_sclk_sync)
   );
   sync_2ff #(.RST_VAL(1'b1)) u_sync_data (
      .clk (clk), .rst (rst), .i_d (bus.serial_data), .o_q (w_sdata_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) r_sclk_prev <= 1'b1;
      else     r_sclk_prev <= w_sclk_sync;
   end

   assign w_edge = w_sclk_sync & ~r_sclk_prev;

   // A serial edge in the timeout cycle takes priority over the abort.
   assign w_timeout = (r_state == ST_RECV) && !w_edge && (r_idle_cnt == IDLE_MAX);

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shift_nxt = {r_shift[WIDTH-2:0], w_sdata_sync};
      end else begin : g_lsb_first
         assign w_shift_nxt = {w_sdata_sync, r_shift[WIDTH-1:1]};
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_edge) w_state_nxt = ST_RECV;
         ST_RECV: begin
            if (w_edge && (r_bit_cnt == LAST_BIT)) w_state_nxt = ST_IDLE;
            else if (w_timeout)                   w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift register, counters and output strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift       <= '0;
         r_word        <= '0;
         r_bit_cnt     <= '0;
         r_idle_cnt    <= '0;
         r_word_valid  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_word_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         if (w_edge) begin
            r_shift    <= w_shift_nxt;
            r_idle_cnt <= '0;
            if (r_bit_cnt == LAST_BIT) begin
               // Final bit goes straight into the published word.
               r_bit_cnt    <= '0;
               r_word       <= w_shift_nxt;
               r_word_valid <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end else if (w_timeout) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_idle_cnt    <= '0;
            r_frame_error <= 1'b1;
         end else if (r_state == ST_RECV) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end else begin
            r_idle_cnt <= '0;
         end
      end
   end

   assign bus.led_word    = r_word;
   assign bus.word_valid  = r_word_valid;
   assign bus.frame_error = r_frame_error;
   assign bus.state       = r_state;
endmodule

// File: tb/tb_led_serial_rx.sv
module tb_led_serial_rx;
  import led_serial_rx_pkg::*;

  localparam int W  = 16;
  localparam int TO = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  led_serial_rx_if #(.WIDTH(W)) ifm ();
  led_serial_rx_if #(.WIDTH(W)) ifl ();

  led_serial_rx #(.WIDTH(W), .TIMEOUT(TO), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk), .rst (rst), .bus (ifm.slave)
  );
  led_serial_rx #(.WIDTH(W), .TIMEOUT(TO), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (ifl.slave)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];    // expected words, MSB-first instance
  logic [W-1:0] exp_l_q[$];  // expected words, LSB-first instance
  logic [W-1:0] obs_m_q[$];
  logic [W-1:0] obs_l_q[$];
  int fe_m_cnt = 0;
  int fe_l_cnt = 0;
  int both_cnt = 0;
  int wv_m_cyc = 0;
  int fe_m_cyc = 0;
  int last_rise_cyc = 0;

  always @(negedge clk) begin
    if (ifm.word_valid === 1'b1) begin
      obs_m_q.push_back(ifm.led_word);
      wv_m_cyc = cyc;
    end
    if (ifl.word_valid === 1'b1) obs_l_q.push_back(ifl.led_word);
    if (ifm.frame_error === 1'b1) begin
      fe_m_cnt++;
      fe_m_cyc = cyc;
    end
    if (ifl.frame_error === 1'b1) fe_l_cnt++;
    if ((ifm.word_valid === 1'b1 && ifm.frame_error === 1'b1) ||
        (ifl.word_valid === 1'b1 && ifl.frame_error === 1'b1)) both_cnt++;
  end

  // ---------------- reference model ----------------
  // Bit k of the frame (k = arrival order) lands at W-1-k when the receiver
  // is MSB-first, at k when it is LSB-first.
  function automatic logic [W-1:0] model_word(input logic bits[W], input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (msb_first) w[W-1-k] = bits[k];
      else           w[k]     = bits[k];
    end
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_bit(input bit sel_l, input logic b, input int hi, input int lo);
    @(negedge clk);
    if (sel_l) begin ifl.serial_data = b; ifl.serial_clk = 1'b1; end
    else       begin ifm.serial_data = b; ifm.serial_clk = 1'b1; end
    last_rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    if (sel_l) ifl.serial_clk = 1'b0;
    else       ifm.serial_clk = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  // Sends a full frame of value in the given wire order and records the
  // word the receiver should publish.
  task automatic send_frame(input bit sel_l, input logic [W-1:0] value,
                            input bit send_msb, input int hi, input int lo);
    logic bits[W];
    for (int i = 0; i < W; i++) begin
      bits[i] = send_msb ? value[W-1-i] : value[i];
      drive_bit(sel_l, bits[i], hi, lo);
    end
    if (sel_l) exp_l_q.push_back(model_word(bits, 1'b0));
    else       exp_q.push_back(model_word(bits, 1'b1));
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_l_q.delete(); obs_m_q.delete(); obs_l_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ifm.serial_clk = 1'b0; ifm.serial_data = 1'b0;
    ifl.serial_clk = 1'b0; ifl.serial_data = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (ifm.led_word !== '0) begin failures++; $display("FAIL reset_led_word got=%h exp=0", ifm.led_word); end
    checks++; if (ifm.word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", ifm.word_valid); end
    checks++; if (ifm.frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", ifm.frame_error); end
    checks++; if (ifm.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", ifm.state, ST_IDLE); end
    checks++; if (ifl.led_word !== '0) begin failures++; $display("FAIL reset_led_word_l got=%h exp=0", ifl.led_word); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_sb();
  endtask

  task automatic test_msb_capture();
    int fe0;
    logic [W-1:0] e;
    clear_sb();
    fe0 = fe_m_cnt;
    send_frame(1'b0, 16'hA5C3, 1'b1, 8, 8);
    repeat (10) @(negedge clk);
    checks++; if (obs_m_q.size() != 1) begin failures++; $display("FAIL msb_pulse_count got=%0d exp=1", obs_m_q.size()); end
    if (obs_m_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL msb_word got=%h exp=%h", obs_m_q[0], e); end
    end
    checks++; if (wv_m_cyc - last_rise_cyc != 3) begin failures++; $display("FAIL msb_latency got=%0d exp=3", wv_m_cyc - last_rise_cyc); end
    checks++; if (ifm.led_word !== 16'hA5C3) begin failures++; $display("FAIL msb_word_hold got=%h exp=a5c3", ifm.led_word); end
    checks++; if (fe_m_cnt != fe0) begin failures++; $display("FAIL msb_no_error got=%0d exp=%0d", fe_m_cnt, fe0); end
  endtask

  task automatic test_lsb_capture();
    logic [W-1:0] e;
    clear_sb();
    send_frame(1'b1, 16'h0001, 1'b0, 8, 8);
    repeat (10) @(negedge clk);
    checks++; if (obs_l_q.size() != 1) begin failures++; $display("FAIL lsb_pulse_count got=%0d exp=1", obs_l_q.size()); end
    if (obs_l_q.size() > 0) begin
      e = exp_l_q.pop_front();
      checks++; if (obs_l_q[0] !== e) begin failures++; $display("FAIL lsb_word got=%h exp=%h", obs_l_q[0], e); end
    end
    checks++; if (ifl.led_word !== 16'h0001) begin failures++; $display("FAIL lsb_word_hold got=%h exp=0001", ifl.led_word); end
  endtask

  task automatic test_timeout();
    int fe0;
    logic [W-1:0] prev;
    logic [W-1:0] e;
    clear_sb();
    fe0  = fe_m_cnt;
    prev = 16'hA5C3;  // word left by the MSB-first capture
    for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)), 8, 8);
    repeat (TO + 20) @(negedge clk);
    checks++; if (fe_m_cnt != fe0 + 1) begin failures++; $display("FAIL timeout_error_count got=%0d exp=%0d", fe_m_cnt, fe0 + 1); end
    checks++; if (fe_m_cyc - last_rise_cyc != TO + 3) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", fe_m_cyc - last_rise_cyc, TO + 3); end
    checks++; if (ifm.led_word !== prev) begin failures++; $display("FAIL timeout_word_kept got=%h exp=%h", ifm.led_word, prev); end
    checks++; if (obs_m_q.size() != 0) begin failures++; $display("FAIL timeout_no_valid got=%0d exp=0", obs_m_q.size()); end
    checks++; if (ifm.state !== ST_IDLE) begin failures++; $display("FAIL timeout_state got=%0d exp=%0d", ifm.state, ST_IDLE); end
    send_frame(1'b0, 16'hFFFF, 1'b1, 8, 8);
    repeat (10) @(negedge clk);
    checks++; if (obs_m_q.size() != 1) begin failures++; $display("FAIL timeout_recover_count got=%0d exp=1", obs_m_q.size()); end
    if (obs_m_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL timeout_recover_word got=%h exp=%h", obs_m_q[0], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    clear_sb();
    send_frame(1'b0, 16'h1234, 1'b1, 3, 3);
    send_frame(1'b0, 16'h8001, 1'b1, 3, 3);
    repeat (10) @(negedge clk);
    checks++; if (obs_m_q.size() != 2) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", obs_m_q.size()); end
    while (obs_m_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL b2b_word got=%h exp=%h", obs_m_q[0], e); end
      void'(obs_m_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    logic [W-1:0] e;
    clear_sb();
    fe0 = fe_m_cnt;
    for (int i = 0; i < 9; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)), 8, 8);
    @(negedge clk);
    ifm.serial_clk = 1'b1; ifm.serial_data = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ifm.led_word !== '0) begin failures++; $display("FAIL midrst_led_word got=%h exp=0", ifm.led_word); end
    checks++; if (ifm.word_valid !== 1'b0 || ifm.frame_error !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b exp=00", ifm.word_valid, ifm.frame_error); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (ifm.state !== ST_IDLE) begin failures++; $display("FAIL midrst_false_edge state=%0d exp=%0d", ifm.state, ST_IDLE); end
    checks++; if (fe_m_cnt != fe0) begin failures++; $display("FAIL midrst_no_error got=%0d exp=%0d", fe_m_cnt, fe0); end
    ifm.serial_clk = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(1'b0, W'($urandom), 1'b1, 5, 5);
    repeat (10) @(negedge clk);
    checks++; if (obs_m_q.size() != 1) begin failures++; $display("FAIL midrst_frame_count got=%0d exp=1", obs_m_q.size()); end
    if (obs_m_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL midrst_frame_word got=%h exp=%h", obs_m_q[0], e); end
    end
  endtask

  task automatic test_coincidence();
    int fe0;
    logic [W-1:0] v;
    logic [W-1:0] e;
    logic bits[W];
    clear_sb();
    fe0 = fe_m_cnt;
    v = W'($urandom);
    for (int i = 0; i < W; i++) begin
      bits[i] = v[W-1-i];
      // 4th bit stretched so the 5th rise is exactly TO cycles later.
      if (i == 3) drive_bit(1'b0, bits[i], 8, TO - 8);
      else        drive_bit(1'b0, bits[i], 8, 8);
    end
    exp_q.push_back(model_word(bits, 1'b1));
    repeat (10) @(negedge clk);
    checks++; if (fe_m_cnt != fe0) begin failures++; $display("FAIL coincide_no_error got=%0d exp=%0d", fe_m_cnt, fe0); end
    checks++; if (obs_m_q.size() != 1) begin failures++; $display("FAIL coincide_count got=%0d exp=1", obs_m_q.size()); end
    if (obs_m_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL coincide_word got=%h exp=%h", obs_m_q[0], e); end
    end
  endtask

  task automatic test_random_frames();
    logic [W-1:0] e;
    int fe0;
    int fe1;
    clear_sb();
    fe0 = fe_m_cnt;
    fe1 = fe_l_cnt;
    for (int n = 0; n < 8; n++) begin
      send_frame(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(3, 10), $urandom_range(3, 10));
    end
    repeat (10) @(negedge clk);
    checks++; if (obs_m_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count_m got=%0d exp=%0d", obs_m_q.size(), exp_q.size()); end
    checks++; if (obs_l_q.size() != exp_l_q.size()) begin failures++; $display("FAIL rand_count_l got=%0d exp=%0d", obs_l_q.size(), exp_l_q.size()); end
    while (obs_m_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (obs_m_q[0] !== e) begin failures++; $display("FAIL rand_word_m got=%h exp=%h", obs_m_q[0], e); end
      void'(obs_m_q.pop_front());
    end
    while (obs_l_q.size() > 0 && exp_l_q.size() > 0) begin
      e = exp_l_q.pop_front();
      checks++; if (obs_l_q[0] !== e) begin failures++; $display("FAIL rand_word_l got=%h exp=%h", obs_l_q[0], e); end
      void'(obs_l_q.pop_front());
    end
    checks++; if (fe_m_cnt != fe0 || fe_l_cnt != fe1) begin failures++; $display("FAIL rand_no_error got=%0d/%0d exp=%0d/%0d", fe_m_cnt, fe_l_cnt, fe0, fe1); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL valid_error_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_msb_capture();
    test_lsb_capture();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_coincidence();
    test_random_frames();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
